// File: rtl/arm_pipeline_core.sv
// arm_pipeline_core: 5-stage (IF/ID/EX/MEM/WB) ARM-subset core without forwarding or interlocks.
// Software spaces dependent instructions; the data RAM is external, synchronous, single-port.
module arm_pipeline_core (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] PC,
   input  logic [31:0] Instruction,
   output logic        write_enable,
   output logic [31:0] WriteAddress,
   output logic [31:0] WriteData,
   input  logic [31:0] ReadData
);

   localparam logic [1:0]  OPDATA     = 2'b00;
   localparam logic [1:0]  OPMEMORY   = 2'b01;
   localparam logic [3:0]  FAND       = 4'b0000;
   localparam logic [3:0]  FEOR       = 4'b0001;
   localparam logic [3:0]  FSUB       = 4'b0010;
   localparam logic [3:0]  FADD       = 4'b0100;
   localparam logic [3:0]  FCMP       = 4'b1010;
   localparam logic [3:0]  FORR       = 4'b1100;
   localparam logic [3:0]  FMOV       = 4'b1101;
   localparam logic [3:0]  COND_NEVER = 4'b1111;
   localparam logic [31:0] NOP_INSTR  = 32'hF000_0000;

   logic [31:0] r_pc;
   logic [31:0] r_regs [0:15];
   logic [3:0]  r_nzcv;

   logic [31:0] r_ifid_instr;

   logic [3:0]  r_idex_cond;
   logic [1:0]  r_idex_op;
   logic [3:0]  r_idex_cmd;
   logic        r_idex_sl;
   logic [3:0]  r_idex_rd;
   logic [31:0] r_idex_a;
   logic [31:0] r_idex_b;
   logic [31:0] r_idex_sd;

   logic        r_exmem_we;
   logic        r_exmem_wb;
   logic        r_exmem_load;
   logic [3:0]  r_exmem_rd;
   logic [31:0] r_exmem_result;
   logic [31:0] r_exmem_sd;

   logic        r_memwb_wb;
   logic        r_memwb_load;
   logic [3:0]  r_memwb_rd;
   logic [31:0] r_memwb_result;

   logic [31:0] w_pc_plus8;
   logic [31:0] w_rn;
   logic [31:0] w_rm;
   logic [31:0] w_rdv;
   logic [31:0] w_rot_imm;
   logic [31:0] w_opb_id;

   logic        w_pass;
   logic        w_sub;
   logic        w_arith;
   logic        w_dp_write;
   logic        w_dp_flags;
   logic [31:0] w_opb;
   logic [32:0] w_sum;
   logic [31:0] w_dp_res;
   logic [31:0] w_mem_addr;
   logic        w_is_dp;
   logic        w_is_mem;
   logic [31:0] w_wb_data;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
      ror32 = (x >> r) | (x << (6'd32 - {1'b0, r}));
   endfunction

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'h0:    cond_ok = z;
         4'h1:    cond_ok = !z;
         4'h2:    cond_ok = cf;
         4'h3:    cond_ok = !cf;
         4'h4:    cond_ok = n;
         4'h5:    cond_ok = !n;
         4'h6:    cond_ok = v;
         4'h7:    cond_ok = !v;
         4'h8:    cond_ok = cf && !z;
         4'h9:    cond_ok = !cf || z;
         4'hA:    cond_ok = (n == v);
         4'hB:    cond_ok = (n != v);
         4'hC:    cond_ok = !z && (n == v);
         4'hD:    cond_ok = z || (n != v);
         4'hE:    cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   endfunction

   assign PC           = r_pc;
   assign write_enable = r_exmem_we;
   assign WriteAddress = r_exmem_result;
   assign WriteData    = r_exmem_sd;

   // ID: regfile read (R15 reads as fetch PC + 8) and operand-2 formation
   assign w_pc_plus8 = r_pc + 32'd8;
   assign w_rn  = (r_ifid_instr[19:16] == 4'd15) ? w_pc_plus8 : r_regs[r_ifid_instr[19:16]];
   assign w_rm  = (r_ifid_instr[3:0]   == 4'd15) ? w_pc_plus8 : r_regs[r_ifid_instr[3:0]];
   assign w_rdv = (r_ifid_instr[15:12] == 4'd15) ? w_pc_plus8 : r_regs[r_ifid_instr[15:12]];
   assign w_rot_imm = ror32({24'd0, r_ifid_instr[7:0]}, {r_ifid_instr[11:8], 1'b0});

   always_comb begin
      w_opb_id = w_rm;
      if (r_ifid_instr[25]) begin
         if (r_ifid_instr[27:26] == OPMEMORY)
            w_opb_id = {20'd0, r_ifid_instr[11:0]};
         else
            w_opb_id = w_rot_imm;
      end
   end

   // EX: condition check, ALU, address generation
   always_comb begin
      w_pass     = cond_ok(r_idex_cond, r_nzcv);
      w_is_dp    = (r_idex_op == OPDATA);
      w_is_mem   = (r_idex_op == OPMEMORY);
      w_sub      = (r_idex_cmd == FSUB) || (r_idex_cmd == FCMP);
      w_arith    = w_sub || (r_idex_cmd == FADD);
      w_opb      = w_sub ? ~r_idex_b : r_idex_b;
      w_sum      = {1'b0, r_idex_a} + {1'b0, w_opb} + {32'd0, w_sub};
      w_mem_addr = r_idex_cmd[2] ? (r_idex_a + r_idex_b) : (r_idex_a - r_idex_b);
      w_dp_write = 1'b1;
      w_dp_res   = w_sum[31:0];
      case (r_idex_cmd)
         FAND:    w_dp_res = r_idex_a & r_idex_b;
         FEOR:    w_dp_res = r_idex_a ^ r_idex_b;
         FSUB,
         FADD:    w_dp_res = w_sum[31:0];
         FORR:    w_dp_res = r_idex_a | r_idex_b;
         FMOV:    w_dp_res = r_idex_b;
         FCMP:    w_dp_write = 1'b0;
         default: w_dp_write = 1'b0;
      endcase
      w_dp_flags = (r_idex_cmd == FCMP) || (r_idex_sl && w_dp_write);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc         <= '0;
         r_nzcv       <= '0;
         r_ifid_instr <= NOP_INSTR;
         r_idex_cond  <= COND_NEVER;
         r_idex_op    <= '0;
         r_idex_cmd   <= '0;
         r_idex_sl    <= 1'b0;
         r_idex_rd    <= '0;
         r_idex_a     <= '0;
         r_idex_b     <= '0;
         r_idex_sd    <= '0;
         r_exmem_we     <= 1'b0;
         r_exmem_wb     <= 1'b0;
         r_exmem_load   <= 1'b0;
         r_exmem_rd     <= '0;
         r_exmem_result <= '0;
         r_exmem_sd     <= '0;
         r_memwb_wb     <= 1'b0;
         r_memwb_load   <= 1'b0;
         r_memwb_rd     <= '0;
         r_memwb_result <= '0;
      end else begin
         r_pc         <= r_pc + 32'd4;
         r_ifid_instr <= Instruction;

         r_idex_cond <= r_ifid_instr[31:28];
         r_idex_op   <= r_ifid_instr[27:26];
         r_idex_cmd  <= r_ifid_instr[24:21];
         r_idex_sl   <= r_ifid_instr[20];
         r_idex_rd   <= r_ifid_instr[15:12];
         r_idex_a    <= w_rn;
         r_idex_b    <= w_opb_id;
         r_idex_sd   <= w_rdv;

         if (w_pass && w_is_dp && w_dp_flags)
            r_nzcv <= {w_dp_res[31], (w_dp_res == 32'd0),
                       w_arith && w_sum[32],
                       w_arith && (r_idex_a[31] == w_opb[31]) && (w_sum[31] != r_idex_a[31])};

         r_exmem_we     <= w_pass && w_is_mem && !r_idex_sl;
         r_exmem_load   <= w_pass && w_is_mem && r_idex_sl;
         r_exmem_wb     <= w_pass && ((w_is_mem && r_idex_sl) || (w_is_dp && w_dp_write));
         r_exmem_rd     <= r_idex_rd;
         r_exmem_result <= w_is_mem ? w_mem_addr : w_dp_res;
         r_exmem_sd     <= r_idex_sd;

         r_memwb_wb     <= r_exmem_wb;
         r_memwb_load   <= r_exmem_load;
         r_memwb_rd     <= r_exmem_rd;
         r_memwb_result <= r_exmem_result;
      end
   end

   // WB: the registered RAM delivers load data during this stage
   assign w_wb_data = r_memwb_load ? ReadData : r_memwb_result;

   always_ff @(posedge clk) begin
      if (r_memwb_wb && (r_memwb_rd != 4'd15))
         r_regs[r_memwb_rd] <= w_wb_data;
   end

endmodule

// File: tb/tb_arm_pipeline_core.sv
// Directed bench for arm_pipeline_core: a short program with a behavioural registered data RAM;
// stores, addresses and flags are compared with hand-computed values at fixed edges after reset.
module tb_arm_pipeline_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        write_enable;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   logic [31:0] prog [0:63];
   logic [31:0] ram  [0:15];
   int          checks = 0;
   int          errors = 0;
   int          edges  = 0;

   arm_pipeline_core dut (
      .clk          (clk),
      .reset        (reset),
      .PC           (PC),
      .Instruction  (Instruction),
      .write_enable (write_enable),
      .WriteAddress (WriteAddress),
      .WriteData    (WriteData),
      .ReadData     (ReadData)
   );

   always #5 clk = ~clk;

   assign Instruction = prog[PC[7:2]];

   always @(posedge clk) begin
      if (write_enable) ram[WriteAddress[5:2]] <= WriteData;
      ReadData <= ram[WriteAddress[5:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick_to(input int n);
      while (edges < n) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) prog[i] = 32'hF000_0000;
      prog[0]  = 32'hE3A00000;  // MOV  R0,#0
      prog[1]  = 32'hE3A03000;  // MOV  R3,#0
      prog[2]  = 32'hE3A044FF;  // MOV  R4,#0xFF000000
      prog[5]  = 32'hE2900001;  // ADDS R0,R0,#1
      prog[6]  = 32'hE0946004;  // ADDS R6,R4,R4
      prog[9]  = 32'hE6030000;  // STR  R0,[R3]
      prog[10] = 32'hE6834004;  // STR  R4,[R3,#4]
      prog[11] = 32'hE6137000;  // LDR  R7,[R3]
      prog[12] = 32'hE6836008;  // STR  R6,[R3,#8]
      prog[15] = 32'hE2971002;  // ADDS R1,R7,#2
      prog[19] = 32'hE6031000;  // STR  R1,[R3]
      prog[20] = 32'hE2532000;  // SUBS R2,R3,#0
      prog[21] = 32'h00000000;  // ANDEQ R0,R0,R0
      prog[22] = 32'h16031000;  // STRNE R1,[R3]
      prog[23] = 32'h06034000;  // STREQ R4,[R3]
      prog[24] = 32'hE6030004;  // STR  R0,[R3,#-4]
      prog[27] = 32'hE1530004;  // CMP  R3,R4
      prog[30] = 32'hE6031000;  // STR  R1,[R3]

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset_pc", PC, 32'd0);
      chk("reset_we", {31'd0, write_enable}, 32'd0);
      chk("reset_waddr", WriteAddress, 32'd0);
      chk("reset_wdata", WriteData, 32'd0);
      chk("reset_nzcv", {28'd0, dut.r_nzcv}, 32'd0);

      tick_to(1);  chk("pc_e1", PC, 32'd4);
      tick_to(2);  chk("pc_e2", PC, 32'd8);
      tick_to(3);  chk("pc_e3", PC, 32'd12);

      tick_to(8);  chk("nzcv_adds_r0", {28'd0, dut.r_nzcv}, 32'h0);
      tick_to(9);  chk("nzcv_adds_carry", {28'd0, dut.r_nzcv}, 32'hA);

      tick_to(12);
      chk("str_r0_we", {31'd0, write_enable}, 32'd1);
      chk("str_r0_addr", WriteAddress, 32'd0);
      chk("str_r0_data", WriteData, 32'd1);
      tick_to(13);
      chk("str_r4_we", {31'd0, write_enable}, 32'd1);
      chk("str_r4_addr", WriteAddress, 32'd4);
      chk("str_r4_data", WriteData, 32'hFF00_0000);
      tick_to(14);
      chk("ldr_we", {31'd0, write_enable}, 32'd0);
      chk("ldr_addr", WriteAddress, 32'd0);
      tick_to(15);
      chk("str_r6_we", {31'd0, write_enable}, 32'd1);
      chk("str_r6_addr", WriteAddress, 32'd8);
      chk("str_r6_data", WriteData, 32'hFE00_0000);
      tick_to(16); chk("nop_we", {31'd0, write_enable}, 32'd0);

      tick_to(18); chk("nzcv_adds_r1", {28'd0, dut.r_nzcv}, 32'h0);
      tick_to(22);
      chk("str_r1_we", {31'd0, write_enable}, 32'd1);
      chk("str_r1_addr", WriteAddress, 32'd0);
      chk("str_r1_data", WriteData, 32'd3);
      tick_to(23);
      chk("nzcv_subs_zero", {28'd0, dut.r_nzcv}, 32'h6);
      chk("subs_no_store", {31'd0, write_enable}, 32'd0);
      tick_to(24);
      chk("andeq_result", WriteAddress, 32'd1);
      tick_to(25); chk("strne_suppressed", {31'd0, write_enable}, 32'd0);
      tick_to(26);
      chk("streq_we", {31'd0, write_enable}, 32'd1);
      chk("streq_data", WriteData, 32'hFF00_0000);
      tick_to(27);
      chk("str_neg_off_addr", WriteAddress, 32'hFFFF_FFFC);
      chk("str_neg_off_data", WriteData, 32'd1);
      tick_to(30); chk("nzcv_cmp", {28'd0, dut.r_nzcv}, 32'h0);

      tick_to(33);
      chk("late_str_we", {31'd0, write_enable}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_we", {31'd0, write_enable}, 32'd0);
      chk("async_reset_pc", PC, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("ram0_kept", ram[0], 32'hFF00_0000);
      chk("ram1", ram[1], 32'hFF00_0000);
      chk("ram2", ram[2], 32'hFE00_0000);
      chk("ram15", ram[15], 32'd1);
      chk("rst2_we", {31'd0, write_enable}, 32'd0);
      edges = 0;
      tick_to(1);  chk("rst2_pc_e1", PC, 32'd4);
      tick_to(2);  chk("rst2_pc_e2", PC, 32'd8);
      tick_to(3);  chk("rst2_pc_e3", PC, 32'd12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
